// File: rtl/otter_mmio_pkg.sv
// Shared types and constants for the OTTER MMIO bridge.
// Optional build macro used by the bridge: OTTER_MMIO_SYNC_EN.
package otter_mmio_pkg;

   // Bridge transaction state
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Byte distance between consecutive channel words
   localparam int WORD_STRIDE = 4;

   // Value the read register takes when a peripheral never acknowledges
   localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

   // Width of a channel index; a single channel still needs one bit
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/otter_mmio_bridge_if.sv
// Hart data-memory port as seen by the MMIO bridge.
// The hart drives the request side (master); the bridge answers (slave).
interface otter_mmio_bridge_if;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_w_data;
   logic [3:0]  dmem_w_strb;
   logic        dmem_w_en;
   logic        dmem_r_en;
   logic [31:0] dmem_r_data;
   logic        dmem_stall;

   modport master (
      output dmem_addr, dmem_w_data, dmem_w_strb, dmem_w_en, dmem_r_en,
      input  dmem_r_data, dmem_stall
   );

   modport slave (
      input  dmem_addr, dmem_w_data, dmem_w_strb, dmem_w_en, dmem_r_en,
      output dmem_r_data, dmem_stall
   );
endinterface

// File: rtl/otter_mmio_sync.sv
// Two-flop synchronizer of configurable width, cleared to 0 on reset.
// Only instantiated by the bridge when OTTER_MMIO_SYNC_EN is defined.
module otter_mmio_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;

   // Two register stages between the foreign domain and the bridge logic
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= '0;
         q        <= '0;
      end else begin
         meta_reg <= d;
         q        <= meta_reg;
      end
   end

endmodule

// File: rtl/otter_mmio_bridge.sv
// OTTER MMIO bridge: decodes a window of NUM_CH word-sized channels at
// IO_BASE, keeps byte-merged output latches, pulses per-channel strobes,
// waits for an acknowledge with a timeout and stalls the hart meanwhile.
// Build macro OTTER_MMIO_SYNC_EN: when defined, io_ack/io_in pass through
// a two-flop synchronizer before use.
module otter_mmio_bridge
   import otter_mmio_pkg::*;
#(
   parameter logic [31:0] IO_BASE = 32'h0001_0000,
   parameter int          NUM_CH  = 4,
   parameter int          TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   otter_mmio_bridge_if.slave     dmem,
   output logic [32*NUM_CH-1:0]   io_out,
   output logic [NUM_CH-1:0]      io_wr,
   output logic [NUM_CH-1:0]      io_rd,
   input  logic [32*NUM_CH-1:0]   io_in,
   input  logic [NUM_CH-1:0]      io_ack,
   output logic [NUM_CH-1:0]      io_err
);

   localparam int          CH_W     = ch_width(NUM_CH);
   localparam int          CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [31:0] WIN_SIZE = 32'(WORD_STRIDE * NUM_CH);

   state_t              state_reg, state_next;
   logic [CH_W-1:0]     lat_ch_reg;
   logic                lat_wr_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [31:0]         rdata_reg;

   logic [31:0]         offset;
   logic                in_window;
   logic                hit;
   logic [CH_W-1:0]     hit_ch;
   logic [NUM_CH-1:0]   hit_dec;
   logic [NUM_CH-1:0]   lat_dec;
   logic                accept;
   logic                in_wait;
   logic                ack_sel;
   logic                timeout_hit;
   logic                cnt_sat;
   logic [31:0]         in_sel;

   logic [NUM_CH-1:0]   ack_use;
   logic [32*NUM_CH-1:0] in_use;

   // Address decode; the two low address bits drop out of the channel index
   assign offset    = dmem.dmem_addr - IO_BASE;
   assign in_window = (dmem.dmem_addr >= IO_BASE) && (offset < WIN_SIZE);
   assign hit       = in_window && (dmem.dmem_w_en || dmem.dmem_r_en);
   assign hit_ch    = offset[CH_W+1:2];

`ifdef OTTER_MMIO_SYNC_EN
   otter_mmio_sync #(.WIDTH(NUM_CH)) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (io_ack),
      .q     (ack_use)
   );

   otter_mmio_sync #(.WIDTH(32*NUM_CH)) u_in_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (io_in),
      .q     (in_use)
   );
`else
   assign ack_use = io_ack;
   assign in_use  = io_in;
`endif

   // Channel decoders for the incoming request and the latched channel
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dec
      assign hit_dec[gi] = (hit_ch == CH_W'(gi));
      assign lat_dec[gi] = (lat_ch_reg == CH_W'(gi));
   end

   assign in_wait     = (state_reg == ST_WAIT);
   assign ack_sel     = |(ack_use & lat_dec);
   assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
   assign cnt_sat     = (cnt_reg == CNT_W'(TIMEOUT));

   // Select the latched channel's read data
   always_comb begin
      in_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (lat_dec[i]) in_sel = in_sel | in_use[32*i +: 32];
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // Next state, hart stall and hart read data
   always_comb begin
      state_next        = state_reg;
      accept            = 1'b0;
      dmem.dmem_stall   = 1'b0;
      dmem.dmem_r_data  = '0;
      case (state_reg)
         ST_IDLE: begin
            if (hit) begin
               accept          = 1'b1;
               dmem.dmem_stall = 1'b1;
               state_next      = ST_WAIT;
            end
         end
         ST_WAIT: begin
            dmem.dmem_stall = 1'b1;
            if (ack_sel || timeout_hit) state_next = ST_DONE;
         end
         ST_DONE: begin
            dmem.dmem_r_data = rdata_reg;
            state_next       = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Latch the transaction, run the timeout counter, capture read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_ch_reg <= '0;
         lat_wr_reg <= 1'b0;
         cnt_reg    <= '0;
         rdata_reg  <= '0;
      end else if (accept) begin
         lat_ch_reg <= hit_ch;
         lat_wr_reg <= dmem.dmem_w_en;
         cnt_reg    <= '0;
      end else if (in_wait) begin
         if (ack_sel) begin
            if (!lat_wr_reg) rdata_reg <= in_sel;
         end else begin
            if (!cnt_sat) cnt_reg <= cnt_reg + 1'b1;
            if (timeout_hit) rdata_reg <= TIMEOUT_RDATA;
         end
      end
   end

   // One-cycle strobes in the first WAIT cycle; a write beats a read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         io_wr <= '0;
         io_rd <= '0;
      end else begin
         io_wr <= (accept &&  dmem.dmem_w_en) ? hit_dec : '0;
         io_rd <= (accept && !dmem.dmem_w_en) ? hit_dec : '0;
      end
   end

   // Per-channel output latch and sticky timeout flag
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [31:0] out_reg;
      logic        err_reg;

      // Merge only the strobed byte lanes on an accepted write
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_reg <= '0;
         end else if (accept && dmem.dmem_w_en && hit_dec[gi]) begin
            for (int b = 0; b < 4; b++) begin
               if (dmem.dmem_w_strb[b]) out_reg[8*b +: 8] <= dmem.dmem_w_data[8*b +: 8];
            end
         end
      end

      // Set on timeout, cleared by a completed acknowledge on this channel
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            err_reg <= 1'b0;
         end else if (in_wait && lat_dec[gi]) begin
            if (ack_sel)          err_reg <= 1'b0;
            else if (timeout_hit) err_reg <= 1'b1;
         end
      end

      assign io_out[32*gi +: 32] = out_reg;
      assign io_err[gi]          = err_reg;
   end

endmodule

// File: tb/tb_otter_mmio_bridge.sv
// Directed self-checking bench for otter_mmio_bridge (NUM_CH=4, TIMEOUT=15).
// Handles both the default build and the OTTER_MMIO_SYNC_EN build.
module tb_otter_mmio_bridge;

   localparam logic [31:0] IO_BASE = 32'h0001_0000;
   localparam int          NUM_CH  = 4;
   localparam int          TIMEOUT = 15;
`ifdef OTTER_MMIO_SYNC_EN
   localparam int          SL      = 2;
`else
   localparam int          SL      = 0;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [32*NUM_CH-1:0]  io_out;
   logic [NUM_CH-1:0]     io_wr;
   logic [NUM_CH-1:0]     io_rd;
   logic [32*NUM_CH-1:0]  io_in;
   logic [NUM_CH-1:0]     io_ack;
   logic [NUM_CH-1:0]     io_err;

   int checks   = 0;
   int failures = 0;

   otter_mmio_bridge_if bus ();

   otter_mmio_bridge #(
      .IO_BASE (IO_BASE),
      .NUM_CH  (NUM_CH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .dmem   (bus),
      .io_out (io_out),
      .io_wr  (io_wr),
      .io_rd  (io_rd),
      .io_in  (io_in),
      .io_ack (io_ack),
      .io_err (io_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_bus();
      bus.dmem_addr   = '0;
      bus.dmem_w_data = '0;
      bus.dmem_w_strb = '0;
      bus.dmem_w_en   = 1'b0;
      bus.dmem_r_en   = 1'b0;
   endtask

   // One hart access held until stall drops; ack raised at cycle ack_cyc
   // (-1: never) on channel ch and held until DONE. Cycle 0 is the request.
   task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic wen, input logic ren,
                         input int ch, input int ack_cyc,
                         output int done_c, output int stall_c,
                         output int wr_c, output int rd_c,
                         output logic [31:0] rdata, output logic early,
                         output logic [31:0] out_at_wr);
      done_c = -1; stall_c = 0; wr_c = 0; rd_c = 0;
      rdata = '0; early = 1'b0; out_at_wr = '0;
      for (int k = 0; k < 40 && done_c < 0; k++) begin
         @(negedge clk);
         if (k == 0) begin
            bus.dmem_addr   = addr;
            bus.dmem_w_data = wdata;
            bus.dmem_w_strb = strb;
            bus.dmem_w_en   = wen;
            bus.dmem_r_en   = ren;
         end
         if (ack_cyc >= 0 && k == ack_cyc) io_ack[ch] = 1'b1;
         #1;
         if (bus.dmem_stall) stall_c++;
         wr_c += $countones(io_wr);
         rd_c += $countones(io_rd);
         if (io_wr[ch]) out_at_wr = io_out[32*ch +: 32];
         if (k > 0 && !bus.dmem_stall) begin
            done_c = k;
            rdata  = bus.dmem_r_data;
         end else if (bus.dmem_r_data !== 32'h0) begin
            early = 1'b1;
         end
      end
      idle_bus();
      io_ack = '0;
   endtask

   int          done_c, st_c, wr_c, rd_c;
   logic [31:0] rd_v, out_v;
   logic        early;
   int          n_str, n_stall;

   initial begin
      idle_bus();
      io_in  = '0;
      io_ack = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_io_out", io_out, '0);
      chk("rst_io_wr",  io_wr,  '0);
      chk("rst_io_rd",  io_rd,  '0);
      chk("rst_io_err", io_err, '0);
      chk("rst_stall",  bus.dmem_stall, 1'b0);
      chk("rst_r_data", bus.dmem_r_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Full-word write to channel 1, ack in the strobe cycle
      access(IO_BASE + 32'd4, 32'hAABBCCDD, 4'hF, 1'b1, 1'b0, 1, 1,
             done_c, st_c, wr_c, rd_c, rd_v, early, out_v);
      $display("write ch1 AABBCCDD strb F: done=%0d stall=%0d wr=%0d", done_c, st_c, wr_c);
      chk("w1_done",     done_c, 2 + SL);
      chk("w1_stall",    st_c,   2 + SL);
      chk("w1_wr_count", wr_c,   1);
      chk("w1_rd_count", rd_c,   0);
      chk("w1_out_at_wr", out_v, 32'hAABBCCDD);

      // Single-lane merge into channel 1
      access(IO_BASE + 32'd4, 32'h00001100, 4'h2, 1'b1, 1'b0, 1, 1,
             done_c, st_c, wr_c, rd_c, rd_v, early, out_v);
      $display("write ch1 00001100 strb 2: done=%0d stall=%0d out=%08h", done_c, st_c, io_out[63:32]);
      chk("w2_done",     done_c, 2 + SL);
      chk("w2_stall",    st_c,   2 + SL);
      chk("w2_wr_count", wr_c,   1);
      chk("w2_io_out",   io_out, {32'h0, 32'h0, 32'hAABB11DD, 32'h0});

      // Read channel 2 with ack three cycles after the read strobe
      io_in[95:64] = 32'h12345678;
      access(IO_BASE + 32'd8, 32'h0, 4'h0, 1'b0, 1'b1, 2, 4,
             done_c, st_c, wr_c, rd_c, rd_v, early, out_v);
      $display("read ch2 late ack: done=%0d stall=%0d rdata=%08h", done_c, st_c, rd_v);
      chk("r2_done",     done_c, 5 + SL);
      chk("r2_stall",    st_c,   5 + SL);
      chk("r2_rd_count", rd_c,   1);
      chk("r2_rdata",    rd_v,   32'h12345678);
      chk("r2_early",    early,  1'b0);
      @(negedge clk); #1;
      chk("r2_rdata_after", bus.dmem_r_data, 32'h0);

      // Read channel 0 with no ack: timeout
      access(IO_BASE, 32'h0, 4'h0, 1'b0, 1'b1, 0, -1,
             done_c, st_c, wr_c, rd_c, rd_v, early, out_v);
      $display("read ch0 timeout: done=%0d rdata=%08h err=%0h", done_c, rd_v, io_err);
      chk("to_done",  done_c, TIMEOUT + 1);
      chk("to_rdata", rd_v,   32'h0);
      chk("to_err",   io_err, 4'b0001);

      // Acked read of channel 0 clears its error
      io_in[31:0] = 32'hCAFEF00D;
      access(IO_BASE, 32'h0, 4'h0, 1'b0, 1'b1, 0, 1,
             done_c, st_c, wr_c, rd_c, rd_v, early, out_v);
      $display("read ch0 acked: done=%0d rdata=%08h err=%0h", done_c, rd_v, io_err);
      chk("rr_rdata", rd_v,   32'hCAFEF00D);
      chk("rr_err",   io_err, 4'b0000);

      // Write and read together on channel 3: write wins
      access(IO_BASE + 32'd12, 32'h11223344, 4'hF, 1'b1, 1'b1, 3, 1,
             done_c, st_c, wr_c, rd_c, rd_v, early, out_v);
      $display("write+read ch3: wr=%0d rd=%0d out=%08h", wr_c, rd_c, io_out[127:96]);
      chk("pr_wr_count", wr_c, 1);
      chk("pr_rd_count", rd_c, 0);
      chk("pr_out",      io_out[127:96], 32'h11223344);

      // Misses just above and just below the window
      n_str = 0; n_stall = 0;
      @(negedge clk);
      bus.dmem_addr = IO_BASE + 32'd16; bus.dmem_w_data = 32'hFFFFFFFF;
      bus.dmem_w_strb = 4'hF; bus.dmem_w_en = 1'b1; bus.dmem_r_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) bus.dmem_addr = IO_BASE - 32'd4;
         #1;
         n_str   += $countones(io_wr) + $countones(io_rd);
         n_stall += int'(bus.dmem_stall);
         @(negedge clk);
      end
      idle_bus();
      #1;
      $display("misses: strobes=%0d stall_cycles=%0d", n_str, n_stall);
      chk("miss_strobes", n_str,   0);
      chk("miss_stall",   n_stall, 0);
      chk("miss_io_out",  io_out, {32'h11223344, 32'h0, 32'hAABB11DD, 32'h0});

      // Address low bits are ignored: byte write at IO_BASE+11 hits channel 2
      access(IO_BASE + 32'd11, 32'h5A5A5A5A, 4'h1, 1'b1, 1'b0, 2, 1,
             done_c, st_c, wr_c, rd_c, rd_v, early, out_v);
      $display("write ch2 via addr+3: out=%08h", io_out[95:64]);
      chk("lowbits_out", io_out[95:64], 32'h0000005A);

      // Timed-out write on channel 3 leaves a sticky error
      access(IO_BASE + 32'd12, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 3, -1,
             done_c, st_c, wr_c, rd_c, rd_v, early, out_v);
      $display("write ch3 timeout: done=%0d err=%0h", done_c, io_err);
      chk("to3_done", done_c, TIMEOUT + 1);
      chk("to3_err",  io_err, 4'b1000);

      // Reset in the middle of a read on channel 1
      @(negedge clk);
      bus.dmem_addr = IO_BASE + 32'd4; bus.dmem_r_en = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("mid_stall_wait", bus.dmem_stall, 1'b1);
      rst_n = 1'b0;
      idle_bus();
      #1;
      $display("reset in WAIT: io_out=%0h err=%0h stall=%0b", io_out, io_err, bus.dmem_stall);
      chk("mid_io_out",  io_out, '0);
      chk("mid_strobes", {io_wr, io_rd}, '0);
      chk("mid_err",     io_err, '0);
      chk("mid_stall",   bus.dmem_stall, 1'b0);
      chk("mid_r_data",  bus.dmem_r_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      n_str = 0; n_stall = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         n_str   += $countones(io_wr) + $countones(io_rd);
         n_stall += int'(bus.dmem_stall);
      end
      $display("after reset release: strobes=%0d stall_cycles=%0d", n_str, n_stall);
      chk("post_rst_strobes", n_str,   0);
      chk("post_rst_stall",   n_stall, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/otter_mmio_bridge.md
# otter_mmio_bridge

Parametrised memory-mapped I/O bridge between the OTTER hart's data-memory port and `NUM_CH` independent peripheral channels. It replaces the single combinational iobus with registered, byte-merged output latches, per-channel write/read strobes, an acknowledge handshake with timeout, and a hart stall. It sits in `otter_soc` beside `otter_mem` and decodes the address window starting at `IO_BASE`.

## Interface
- `IO_BASE`, default 32'h0001_0000: first I/O byte address. Equals the default `MEM_SIZE`.
- `NUM_CH`, default 4: channel count, 1..16. Each channel occupies one word; channel `c` is at `IO_BASE + 4*c`.
- `TIMEOUT`, default 15: maximum number of WAIT cycles without `io_ack`, 1..255.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `dmem_addr` in 32: hart byte address.
- `dmem_w_data` in 32: hart store data.
- `dmem_w_strb` in 4: byte-lane strobes.
- `dmem_w_en` in 1: store request.
- `dmem_r_en` in 1: load request.
- `dmem_r_data` out 32: load return data, valid only in DONE.
- `dmem_stall` out 1: hart must hold its request while high.
- `io_out` out 32*NUM_CH: per-channel output latches, flattened with channel 0 in the LSBs.
- `io_wr` out NUM_CH: one-cycle write strobe.
- `io_rd` out NUM_CH: one-cycle read strobe.
- `io_in` in 32*NUM_CH: per-channel read data.
- `io_ack` in NUM_CH: peripheral completion.
- `io_err` out NUM_CH: sticky timeout flag per channel.

## Operation
- Hit condition: `IO_BASE <= dmem_addr < IO_BASE + 4*NUM_CH`. Channel index is `(dmem_addr - IO_BASE) >> 2`. `dmem_addr[1:0]` is ignored.
- Misses: the bridge ignores the request, and `dmem_stall` stays 0.
- Simultaneous `dmem_w_en` and `dmem_r_en` on a hit: the write wins and the read is dropped.
- State machine IDLE, WAIT, DONE:
  - IDLE -> WAIT on a hit. The bridge latches the channel index, direction, data and strobes.
    - On a write, it merges the data into `io_out[ch]` per byte, updating only lanes whose `dmem_w_strb` bit is set.
    - It pulses `io_wr[ch]` or `io_rd[ch]` in the first WAIT cycle and clears the timeout counter.
  - WAIT -> DONE when the latched channel's `io_ack` is high. On a read, the bridge captures `io_in[ch]` into the read register. It clears `io_err[ch]`.
  - WAIT -> DONE when the counter reaches `TIMEOUT` without an ack. The bridge sets `io_err[ch]`, and the read register becomes 32'h0. The counter increments in each WAIT cycle without an ack.
  - DONE -> IDLE unconditionally. In DONE the bridge ignores any new request, including a back-to-back one, until it is back in IDLE.
- `dmem_stall` is combinational: 1 when a hit is present in IDLE, and 1 for the whole of WAIT. It is 0 in DONE.
- `io_ack` is sampled only in WAIT. An ack on a non-latched channel, or outside WAIT, has no effect.
- `dmem_r_data` is the read register in DONE and 0 otherwise.
- Reset values (asynchronous, on `rst_n` low):
  - `io_out` all 0.
  - `io_wr`, `io_rd` and `io_err` all 0.
  - State IDLE, timeout counter 0, read register 0.
- Reset mid-transaction aborts it. No strobe is reissued after reset.

## Timing
- Request at cycle 0 → `io_wr` or `io_rd` at cycle 1 → earliest ack at cycle 1 → DONE at cycle 2, with `dmem_stall` 0. Minimum latency is 3 cycles.
- `io_out[ch]` holds the new value from cycle 1, coincident with `io_wr`.
- Worst case without an ack: DONE at cycle `TIMEOUT + 1`.
- The counter is `$clog2(TIMEOUT+1)` bits wide and saturating.

## Configuration
- `OTTER_MMIO_SYNC_EN` defined:
  - `io_ack` and `io_in` pass through a two-flop synchronizer per channel before use.
  - Ack-to-DONE latency grows by 2 cycles.
  - `TIMEOUT` counts synchronized cycles.
- Undefined: `io_ack` and `io_in` are used directly. Peripherals must then be synchronous to `clk`.

## Structure
- Package `otter_mmio_pkg` holds:
  - State encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2).
  - The word-stride constant (4).
  - The timeout read value (32'h0).
- Sub-module `otter_mmio_sync`: parametrised-width two-flop synchronizer with asynchronous active-low reset to 0. It is instantiated only under `OTTER_MMIO_SYNC_EN`.

## Test plan
- **Byte-merge write.** Write 32'hAABBCCDD with strobe 4'hF to channel 1, then 32'h00001100 with strobe 4'h2, acking in the strobe cycle each time. Required: `io_out[1]` = 32'hAABB11DD, one `io_wr[1]` pulse per write, stall 2 cycles per access.
- **Read with late ack.** Read channel 2 with `io_in[2]` = 32'h12345678 and ack 3 cycles after `io_rd`. Required: `dmem_r_data` = 32'h12345678 in DONE only, stall high throughout WAIT.
- **Timeout.** Read channel 0 with no ack. Required: DONE at cycle 16, `dmem_r_data` = 0, `io_err[0]` = 1. A following acked read clears `io_err[0]`.
- **Priority and miss.** Assert write and read together on channel 3. Required: only `io_wr[3]` pulses. Then access `IO_BASE + 4*NUM_CH`. Required: no strobes, stall 0.
- **Reset mid-operation.** Drop `rst_n` in WAIT. Required: immediately all outputs 0 and state IDLE. After release, no spurious strobe.
- **Sync build (`OTTER_MMIO_SYNC_EN`).** Ack at cycle 1. Required: DONE at cycle 4, read data equals synchronized `io_in`.
